// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: fixed-priority scanout fetch vs Wishbone pixel R/W on one RAM port.
// Optional starvation guard for the Wishbone side is enabled by defining ARB_STARVE_GUARD_EN.
module vga_fb_arbiter #(
  parameter int unsigned FB_WIDTH     = 640,
  parameter int unsigned FB_HEIGHT    = 480,
  parameter int unsigned PIXEL_W      = 24,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  // Wishbone slave
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  // Scanout fetch
  input  logic               scan_req_i,
  input  logic [ADDR_W-1:0]  scan_addr_i,
  output logic               scan_gnt_o,
  output logic               scan_valid_o,
  output logic [PIXEL_W-1:0] scan_data_o,
  // Framebuffer RAM
  output logic               ram_en_o,
  output logic               ram_we_o,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic [PIXEL_W-1:0] ram_wdata_o,
  input  logic [PIXEL_W-1:0] ram_rdata_i
);

  localparam int unsigned FbPixels = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {WbIdle, WbRd, WbAck} wb_state_e;

  wb_state_e          state_q, state_d;
  logic [PIXEL_W-1:0] rdata_q, rdata_d;
  logic               scan_valid_q, scan_oor_q;

  logic [ADDR_W-1:0]  wb_idx;
  logic               wb_req, wb_oor, wb_gnt;
  logic               scan_oor, scan_gnt;
  logic               force_wb;

  assign wb_idx   = addr_i[ADDR_W+1:2];
  assign wb_oor   = 32'(wb_idx) >= FbPixels;
  assign scan_oor = 32'(scan_addr_i) >= FbPixels;
  assign wb_req   = cyc_i && stb_i && (state_q == WbIdle);

  // Out-of-range Wishbone accesses never touch the RAM, so they are not part of arbitration.
  assign scan_gnt = scan_req_i && !force_wb;
  assign wb_gnt   = wb_req && !wb_oor && (!scan_req_i || force_wb);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       unused_bits;

  assign force_wb = wb_req && !wb_oor && (wait_cnt_q == StarveLimit);

  always_comb begin
    wait_cnt_d = '0;
    if (wb_req && !wb_oor && !wb_gnt) begin
      wait_cnt_d = (wait_cnt_q == StarveLimit) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign unused_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0], data_i[31:PIXEL_W]};
`else
  logic unused_bits;

  assign force_wb    = 1'b0;
  assign unused_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0], data_i[31:PIXEL_W], 8'(STARVE_LIMIT)};
`endif

  // RAM port: scanout wins unless the guard forces a Wishbone slot.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (scan_gnt) begin
      if (!scan_oor) begin
        ram_en_o   = 1'b1;
        ram_addr_o = scan_addr_i;
      end
    end else if (wb_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = we_i;
      ram_addr_o  = wb_idx;
      ram_wdata_o = data_i[PIXEL_W-1:0];
    end
  end

  // Wishbone FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WbIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Wishbone FSM: next state
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      WbIdle: begin
        if (wb_req && wb_oor) begin
          state_d = WbAck;
          if (!we_i) begin
            rdata_d = '0;
          end
        end else if (wb_gnt) begin
          state_d = we_i ? WbAck : WbRd;
        end
      end
      WbRd: begin
        // Master gave up mid-read: drop the access silently.
        if (!cyc_i) begin
          state_d = WbIdle;
        end else begin
          state_d = WbAck;
          rdata_d = ram_rdata_i;
        end
      end
      WbAck:   state_d = WbIdle;
      default: state_d = WbIdle;
    endcase
  end

  // Wishbone FSM: outputs
  always_comb begin
    ack_o  = (state_q == WbAck);
    data_o = 32'(rdata_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_valid_q <= 1'b0;
      scan_oor_q   <= 1'b0;
    end else begin
      scan_valid_q <= scan_gnt;
      scan_oor_q   <= scan_gnt && scan_oor;
    end
  end

  assign scan_valid_o = scan_valid_q;
  assign scan_gnt_o   = scan_gnt;
  assign scan_data_o  = scan_oor_q ? '0 : ram_rdata_i;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed Wishbone/scanout traffic checked every cycle against a
// transaction-level reference model; honours ARB_STARVE_GUARD_EN like the design.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int unsigned Limit = 4;
  localparam int unsigned NPix  = 640 * 480;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        scan_req_i = 1'b0;
  logic [18:0] scan_addr_i = '0;
  logic        scan_gnt_o, scan_valid_o;
  logic [23:0] scan_data_o;
  logic        ram_en_o, ram_we_o;
  logic [18:0] ram_addr_o;
  logic [23:0] ram_wdata_o;
  logic [23:0] ram_rdata_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  vga_fb_arbiter #(
    .FB_WIDTH    (640),
    .FB_HEIGHT   (480),
    .PIXEL_W     (24),
    .ADDR_W      (19),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .scan_req_i  (scan_req_i),
    .scan_addr_i (scan_addr_i),
    .scan_gnt_o  (scan_gnt_o),
    .scan_valid_o(scan_valid_o),
    .scan_data_o (scan_data_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // The framebuffer RAM itself
  bit [23:0] ram [0:(1<<19)-1];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i <= ram[ram_addr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel memory plus the cycle numbers at which responses are due.
  bit [23:0] mem [0:(1<<19)-1];
  int        cyc_n = 0;
  int        ack_at = -1, rd_at = -1, scan_at = -1, free_at = 0, waited = 0;
  bit        ack_rd = 1'b0, model_ok = 1'b0;
  bit [23:0] ack_px = '0, scan_px = '0;

  always @(negedge clk) begin : p_model
    logic [18:0] idx;
    bit          wreq, woor, soor, frc, sgnt, wgnt, en_e;
    idx  = addr_i[20:2];
    wreq = cyc_i && stb_i && (cyc_n >= free_at);
    woor = idx >= NPix;
    soor = scan_addr_i >= NPix;
    frc  = Guard && wreq && !woor && (waited == Limit);
    sgnt = scan_req_i && !frc;
    wgnt = wreq && !woor && (!scan_req_i || frc);
    en_e = (sgnt && !soor) || wgnt;

    if (model_ok) begin
      chk("ack_o", 32'(ack_o), 32'(cyc_n == ack_at));
      chk("scan_valid_o", 32'(scan_valid_o), 32'(cyc_n == scan_at));
      if (cyc_n == scan_at) chk("scan_data_o", 32'(scan_data_o), 32'(scan_px));
      if (cyc_n == ack_at && ack_rd) chk("data_o", data_o, 32'(ack_px));
      chk("data_o_upper", 32'(data_o[31:24]), 32'd0);
      if (!rst) begin
        chk("scan_gnt_o", 32'(scan_gnt_o), 32'(sgnt));
        chk("ram_en_o", 32'(ram_en_o), 32'(en_e));
        if (en_e) begin
          chk("ram_we_o", 32'(ram_we_o), 32'(wgnt && we_i));
          chk("ram_addr_o", 32'(ram_addr_o), wgnt ? 32'(idx) : 32'(scan_addr_i));
          if (wgnt && we_i) chk("ram_wdata_o", 32'(ram_wdata_o), 32'(data_i[23:0]));
        end
      end
    end

    if (rst) begin
      ack_at   = -1;
      rd_at    = -1;
      scan_at  = -1;
      free_at  = cyc_n + 1;
      waited   = 0;
      model_ok = 1'b1;
    end else begin
      if (cyc_n == rd_at && !cyc_i) begin
        ack_at  = -1;
        free_at = cyc_n + 1;
      end
      if (sgnt) begin
        scan_at = cyc_n + 1;
        scan_px = soor ? 24'd0 : mem[scan_addr_i];
      end
      if (wreq && woor) begin
        ack_at  = cyc_n + 1;
        ack_rd  = !we_i;
        ack_px  = '0;
        free_at = cyc_n + 2;
      end else if (wgnt) begin
        if (we_i) begin
          mem[idx] = data_i[23:0];
          ack_at   = cyc_n + 1;
          ack_rd   = 1'b0;
          free_at  = cyc_n + 2;
        end else begin
          rd_at   = cyc_n + 1;
          ack_at  = cyc_n + 2;
          ack_rd  = 1'b1;
          ack_px  = mem[idx];
          free_at = cyc_n + 3;
        end
      end
      if (wreq && !woor && !wgnt) waited = (waited < int'(Limit)) ? waited + 1 : waited;
      else                        waited = 0;
    end
    cyc_n++;
  end

  // One Wishbone transfer; cycle counts are 1-based from the first request cycle, 0 = none.
  task automatic wb_op(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input int max_n, output int ack_n, output int den_n, output bit en1,
                       output bit we1, output logic [31:0] rd);
    ack_n = 0;
    den_n = 0;
    en1   = 1'b0;
    we1   = 1'b0;
    rd    = '0;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = adr; data_i = dat;
    for (int n = 1; n <= max_n; n++) begin
      @(negedge clk);
      if (n == 1) begin
        en1 = ram_en_o;
        we1 = ram_we_o;
      end
      if (scan_req_i && !scan_gnt_o && den_n == 0) den_n = n;
      if (ack_o) begin
        ack_n = n;
        rd    = data_o;
        break;
      end
    end
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  // Scanout requests for cnt cycles; the address only advances once a fetch is granted.
  task automatic scan_hold(input int cnt, input int base, output int gcnt);
    int k;
    k    = 0;
    gcnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < cnt; i++) begin
      scan_req_i  = 1'b1;
      scan_addr_i = (k % 4 == 3) ? 19'(NPix) : 19'(base + k % 16);
      @(negedge clk);
      if (scan_gnt_o) begin
        gcnt++;
        k++;
      end
      @(posedge clk); #1;
    end
    scan_req_i = 1'b0;
  endtask

  initial begin : p_stim
    int          an, dn, g;
    bit          e1, w1;
    logic [31:0] rd;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ack_o", 32'(ack_o), 32'd0);
    chk("reset scan_valid_o", 32'(scan_valid_o), 32'd0);
    chk("reset data_o", data_o, 32'd0);

    // Write then read pixel 100, no scanout traffic
    wb_op(1'b1, 32'd400, 32'hFFAB_CDEF, 20, an, dn, e1, w1, rd);
    chk("t1 write ram_en", 32'(e1), 32'd1);
    chk("t1 write ram_we", 32'(w1), 32'd1);
    chk("t1 write ack cycle", 32'(an), 32'd2);
    wb_op(1'b0, 32'd400, 32'd0, 20, an, dn, e1, w1, rd);
    chk("t1 read ack cycle", 32'(an), 32'd3);
    chk("t1 read data", rd, 32'h00AB_CDEF);

    // Last valid pixel
    wb_op(1'b1, 32'(4 * 307199), 32'h00C0_FFEE, 20, an, dn, e1, w1, rd);
    chk("last pixel write ack", 32'(an), 32'd2);
    wb_op(1'b0, 32'(4 * 307199), 32'd0, 20, an, dn, e1, w1, rd);
    chk("last pixel read data", rd, 32'h00C0_FFEE);

    // Scanout holds the RAM for 3 cycles; the read is granted on cycle 4
    fork
      scan_hold(3, 100, g);
      wb_op(1'b0, 32'd400, 32'd0, 40, an, dn, e1, w1, rd);
    join
    chk("t2 read ack cycle", 32'(an), 32'd6);
    chk("t2 read data", rd, 32'h00AB_CDEF);
    chk("t2 scan grants", 32'(g), 32'd3);

    // Continuous scanout against a pending write: forced slot or indefinite starvation
    fork
      scan_hold(Guard ? 12 : 1002, 307190, g);
      wb_op(1'b1, 32'd200, 32'h0012_3456, 1000, an, dn, e1, w1, rd);
    join
    chk("t3 ack cycle", 32'(an), Guard ? 32'd6 : 32'd0);
    chk("t3 denied scan cycle", 32'(dn), Guard ? 32'd5 : 32'd0);
    chk("t3 scan grants", 32'(g), Guard ? 32'd11 : 32'd1002);

    // Out-of-range Wishbone accesses
    wb_op(1'b1, 32'(4 * 307200), 32'h0077_7777, 20, an, dn, e1, w1, rd);
    chk("t5 write ram_en", 32'(e1), 32'd0);
    chk("t5 write ack cycle", 32'(an), 32'd2);
    wb_op(1'b0, 32'(4 * 307200), 32'd0, 20, an, dn, e1, w1, rd);
    chk("t5 read ack cycle", 32'(an), 32'd2);
    chk("t5 read data", rd, 32'd0);
    fork
      scan_hold(4, 10, g);
      wb_op(1'b0, 32'(4 * 307200), 32'd0, 20, an, dn, e1, w1, rd);
    join
    chk("t5 oor under scan ack", 32'(an), 32'd2);
    chk("t5 oor under scan grants", 32'(g), 32'd4);

    // Read abandoned in its data cycle: no ack, next read still works
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'd400;
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    g = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o) g++;
    end
    chk("abort ack count", 32'(g), 32'd0);
    wb_op(1'b0, 32'd400, 32'd0, 20, an, dn, e1, w1, rd);
    chk("after abort read data", rd, 32'h00AB_CDEF);

    // Reset during the read data cycle, then an immediate write
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'd400;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; we_i = 1'b1; data_i = 32'h0055_00AA;
    @(negedge clk);
    chk("t6 ack after reset", 32'(ack_o), 32'd0);
    chk("t6 scan_valid after reset", 32'(scan_valid_o), 32'd0);
    chk("t6 write accepted", 32'(ram_we_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6 write ack", 32'(ack_o), 32'd1);
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    wb_op(1'b0, 32'd400, 32'd0, 20, an, dn, e1, w1, rd);
    chk("t6 readback", rd, 32'h0055_00AA);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
